// File: rtl/uart_rx_deserializer_pkg.sv
// uart_rx_pkg: shared types and helpers for the UART receive deserializer.
//   - rx_state_e          : receive FSM state encoding
//   - SAMPLE_MID          : mid-bit sample point for the default oversample rate
//   - FRAME_BITS_*        : frame length in bits without/with parity
//   - PAR_TYP_*           : PAR_TYP encoding (even/odd)
//   - sample_mid()        : mid-bit sample point for any oversample rate
//   - majority3()         : 2-of-3 vote used on the mid-bit captures
//   - expected_parity()   : parity bit the transmitter should have sent
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE_DEFAULT = 8;
  localparam int SAMPLE_MID         = OVERSAMPLE_DEFAULT / 2;
  localparam int FRAME_BITS_NOPAR   = 10;
  localparam int FRAME_BITS_PAR     = 11;

  localparam logic PAR_TYP_EVEN = 1'b0;
  localparam logic PAR_TYP_ODD  = 1'b1;

  function automatic int sample_mid(input int os);
    return os / 2;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Payload is zero-extended by the caller; extra zeros do not change the XOR.
  function automatic logic expected_parity(input logic [31:0] payload, input logic par_typ);
    return (^payload) ^ (par_typ == PAR_TYP_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if: serial line, frame configuration and receive results.
//   RX_IN      : serial line, idle high            (master -> slave)
//   PAR_EN     : frame carries a parity bit        (master -> slave)
//   PAR_TYP    : 0 even, 1 odd parity              (master -> slave)
//   P_DATA     : last good payload                 (slave -> master)
//   data_valid : one-cycle good-frame pulse        (slave -> master)
//   par_err    : one-cycle parity-mismatch pulse   (slave -> master)
//   stop_err   : one-cycle bad-stop-bit pulse      (slave -> master)
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stop_err;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stop_err
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stop_err
  );
endinterface

// File: rtl/uart_rx_deserializer_sampler.sv
// uart_rx_data_sampler: captures rx_s at the three mid-bit points of every
// bit period and votes them down to one bit value.
//   CLK, RST     : clock, async active-low reset
//   rx_s         : synchronized serial line
//   edge_cnt     : position within the current bit (0..OVERSAMPLE-1)
//   sample_bit   : 2-of-3 majority of the captures
//   sample_ready : high in the cycle sample_bit first reflects this bit
module uart_rx_data_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             rx_s,
  input  logic [CNT_W-1:0] edge_cnt,
  output logic             sample_bit,
  output logic             sample_ready
);

  localparam int MID = sample_mid(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CAP0  = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CAP1  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CAP2  = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] READY = CNT_W'(MID + 2);

  logic [2:0] samples_r;

  // Three-point capture around the bit centre; idle-high reset value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samples_r <= 3'b111;
    end else begin
      case (edge_cnt)
        CAP0:    samples_r[0] <= rx_s;
        CAP1:    samples_r[1] <= rx_s;
        CAP2:    samples_r[2] <= rx_s;
        default: samples_r    <= samples_r;
      endcase
    end
  end

  assign sample_bit   = majority3(samples_r[0], samples_r[1], samples_r[2]);
  assign sample_ready = (edge_cnt == READY);

endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampled UART receiver, LSB-first 8-bit frames with
// optional parity and one stop bit.
//   CLK : clock, all logic on the rising edge
//   RST : asynchronous active-low reset
//   bus : slave side of uart_rx_deserializer_if (RX_IN, PAR_EN, PAR_TYP in;
//         P_DATA, data_valid, par_err, stop_err out, all outputs registered)
module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_rx_deserializer_if.slave bus
);

  localparam int CNT_W     = $clog2(OVERSAMPLE);
  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 3);

  localparam logic [CNT_W-1:0]     EDGE_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]     EDGE_ONE  = CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_WIDTH);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1);

  logic                  sync1_r;
  logic                  sync2_r;
  logic                  rx_s;
  rx_state_e             state_r;
  rx_state_e             next_state_s;
  logic [CNT_W-1:0]      edge_cnt_r;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic                  par_mismatch_r;
  logic                  stop_bit_r;
  logic [DATA_WIDTH-1:0] p_data_r;
  logic                  data_valid_r;
  logic                  par_err_r;
  logic                  stop_err_r;
  logic                  frame_start_s;
  logic                  frame_done_s;
  logic                  bit_end_s;
  logic                  sample_bit_s;
  logic                  sample_ready_s;

  // Two-flop synchronizer for the asynchronous line, reset to idle-high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= bus.RX_IN;
      sync2_r <= sync1_r;
    end
  end

  assign rx_s      = sync2_r;
  assign bit_end_s = (edge_cnt_r == EDGE_LAST);

  uart_rx_data_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_W      (CNT_W)
  ) u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .rx_s         (rx_s),
    .edge_cnt     (edge_cnt_r),
    .sample_bit   (sample_bit_s),
    .sample_ready (sample_ready_s)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic and frame start/done strobes.
  always_comb begin
    next_state_s  = state_r;
    frame_start_s = 1'b0;
    frame_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          next_state_s  = ST_START;
          frame_start_s = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        // A start bit that votes high was a glitch: abandon it mid-bit.
        if (sample_ready_s && sample_bit_s) begin
          next_state_s = ST_IDLE;
        end else if (bit_end_s) begin
          next_state_s = ST_DATA;
        end else begin
          next_state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && (bit_cnt_r == DATA_LAST)) begin
          next_state_s = par_en_r ? ST_PARITY : ST_STOP;
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          next_state_s = ST_STOP;
        end else begin
          next_state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          next_state_s = ST_IDLE;
          frame_done_s = 1'b1;
        end else begin
          next_state_s = ST_STOP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Bit/edge counters and per-frame configuration latch. The detect cycle is
  // edge 0 of the start bit, so the counter restarts at 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_r <= {CNT_W{1'b0}};
      bit_cnt_r  <= {BIT_CNT_W{1'b0}};
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
    end else if (frame_start_s) begin
      edge_cnt_r <= EDGE_ONE;
      bit_cnt_r  <= {BIT_CNT_W{1'b0}};
      par_en_r   <= bus.PAR_EN;
      par_typ_r  <= bus.PAR_TYP;
    end else if (state_r == ST_IDLE) begin
      edge_cnt_r <= {CNT_W{1'b0}};
      bit_cnt_r  <= {BIT_CNT_W{1'b0}};
    end else if (bit_end_s) begin
      edge_cnt_r <= {CNT_W{1'b0}};
      bit_cnt_r  <= bit_cnt_r + BIT_ONE;
    end else begin
      edge_cnt_r <= edge_cnt_r + EDGE_ONE;
    end
  end

  // Payload shift register (LSB first), parity check and stop-bit capture.
  // expected_parity takes 32 bits, so DATA_WIDTH must not exceed 32.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_r        <= {DATA_WIDTH{1'b0}};
      par_mismatch_r <= 1'b0;
      stop_bit_r     <= 1'b1;
    end else if (frame_start_s) begin
      par_mismatch_r <= 1'b0;
      stop_bit_r     <= 1'b1;
    end else if (sample_ready_s) begin
      case (state_r)
        ST_DATA:   shift_r        <= {sample_bit_s, shift_r[DATA_WIDTH-1:1]};
        ST_PARITY: par_mismatch_r <= (expected_parity(32'(shift_r), par_typ_r) != sample_bit_s);
        ST_STOP:   stop_bit_r     <= sample_bit_s;
        default:   shift_r        <= shift_r;
      endcase
    end
  end

  // Registered result pulses; P_DATA only moves on a clean frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_data_r     <= {DATA_WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stop_err_r   <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stop_err_r   <= 1'b0;
      if (frame_done_s) begin
        stop_err_r <= ~stop_bit_r;
        par_err_r  <= par_en_r & par_mismatch_r;
        if (stop_bit_r && !(par_en_r && par_mismatch_r)) begin
          data_valid_r <= 1'b1;
          p_data_r     <= shift_r;
        end
      end
    end
  end

  assign bus.P_DATA     = p_data_r;
  assign bus.data_valid = data_valid_r;
  assign bus.par_err    = par_err_r;
  assign bus.stop_err   = stop_err_r;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed and random frames against a frame-level
// model (bit list in, expected pulse cycle and outcome out).
module tb_uart_rx_deserializer;
  import uart_rx_pkg::*;

  localparam int OS = OVERSAMPLE_DEFAULT;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   cyc = 0;

  uart_rx_deserializer_if #(.DATA_WIDTH(8)) bus();

  uart_rx_deserializer #(.OVERSAMPLE(OS), .DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
  } ev_t;

  ev_t ev_q[$];

  // Record every cycle in which any result pulse is high.
  always @(negedge CLK) begin
    if (bus.data_valid || bus.par_err || bus.stop_err)
      ev_q.push_back('{cyc, bus.data_valid, bus.par_err, bus.stop_err, bus.P_DATA});
  end

  int         n_assert = 0;
  int         n_fail   = 0;
  int         rd_idx   = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic model_parity(input logic [7:0] d, input logic typ);
    return (^d) ^ typ;
  endfunction

  // Drive one frame; caller must be 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic pbit, input logic sbit, output int st);
    logic [10:0] bits;
    int nb;
    bits = 11'h7FF;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pen) begin
      bits[9] = pbit; bits[10] = sbit; nb = FRAME_BITS_PAR;
    end else begin
      bits[9] = sbit; nb = FRAME_BITS_NOPAR;
    end
    bus.PAR_EN  = pen;
    bus.PAR_TYP = ptyp;
    st = cyc;
    for (int i = 0; i < nb; i++) begin
      bus.RX_IN = bits[i];
      // Configuration changes mid-frame must not affect this frame.
      if (i == 3) begin
        bus.PAR_EN  = 1'($urandom);
        bus.PAR_TYP = 1'($urandom);
      end
      tick(OS);
    end
  endtask

  task automatic check_count(input string tag, input int n);
    chk({tag, "_npulse"}, ev_q.size() - rd_idx, n);
  endtask

  task automatic check_ev(input string tag, input int exp_cyc, input logic dv,
                          input logic pe, input logic se, input logic [7:0] pd);
    ev_t e;
    if (ev_q.size() > rd_idx) begin
      e = ev_q[rd_idx];
      chk({tag, "_cyc"},   e.c,  exp_cyc);
      chk({tag, "_dv"},    e.dv, dv);
      chk({tag, "_pe"},    e.pe, pe);
      chk({tag, "_se"},    e.se, se);
      chk({tag, "_pdata"}, e.pd, pd);
      rd_idx++;
    end
  endtask

  // Send one frame, let the line idle, and compare against the model.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                           input logic ptyp, input logic pbit, input logic sbit);
    int st, nb;
    logic pe, se, dv;
    send_frame(d, pen, ptyp, pbit, sbit, st);
    bus.RX_IN = 1'b1;
    tick(4);
    nb = pen ? FRAME_BITS_PAR : FRAME_BITS_NOPAR;
    pe = pen && (pbit != model_parity(d, ptyp));
    se = !sbit;
    dv = !pe && !se;
    if (dv) last_good = d;
    check_count(tag, 1);
    check_ev(tag, st + nb * OS + 2, dv, pe, se, last_good);
    chk({tag, "_pdata_hold"}, bus.P_DATA, last_good);
  endtask

  initial begin
    int st1, st2, c0;
    logic [7:0] d;
    logic pen, ptyp, pbit, sbit;

    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = PAR_TYP_EVEN;
    tick(3);
    chk("rst_pdata", bus.P_DATA, 8'h00);
    chk("rst_dv",    bus.data_valid, 1'b0);
    chk("rst_pe",    bus.par_err, 1'b0);
    chk("rst_se",    bus.stop_err, 1'b0);
    RST = 1'b1;
    tick(5);

    // Basic frames, parity variants and a stop error.
    run_frame("a5_nopar",   8'hA5, 1'b0, PAR_TYP_EVEN, 1'b0, 1'b1);
    run_frame("3c_even_ok", 8'h3C, 1'b1, PAR_TYP_EVEN, 1'b0, 1'b1);
    run_frame("3c_even_bad",8'h3C, 1'b1, PAR_TYP_EVEN, 1'b1, 1'b1);
    run_frame("3c_odd_ok",  8'h3C, 1'b1, PAR_TYP_ODD,  1'b1, 1'b1);
    run_frame("01_stop0",   8'h01, 1'b1, PAR_TYP_ODD,  model_parity(8'h01, PAR_TYP_ODD), 1'b0);
    run_frame("both_err",   8'h7E, 1'b1, PAR_TYP_EVEN, 1'b1, 1'b0);

    // Two-cycle low glitch must be rejected.
    c0 = cyc;
    bus.RX_IN = 1'b0;
    tick(2);
    bus.RX_IN = 1'b1;
    tick(c0 + 2 + SAMPLE_MID + 2 - cyc);
    chk("glitch_busy", (dut.state_r == ST_IDLE), 1'b0);
    tick(1);
    chk("glitch_idle", (dut.state_r == ST_IDLE), 1'b1);
    tick(20);
    check_count("glitch", 0);
    run_frame("5a_after_glitch", 8'h5A, 1'b0, PAR_TYP_EVEN, 1'b0, 1'b1);

    // Back-to-back frames with no idle gap.
    send_frame(8'h11, 1'b0, PAR_TYP_EVEN, 1'b0, 1'b1, st1);
    send_frame(8'hEE, 1'b0, PAR_TYP_EVEN, 1'b0, 1'b1, st2);
    bus.RX_IN = 1'b1;
    tick(4);
    check_count("b2b", 2);
    if (ev_q.size() >= rd_idx + 2)
      chk("b2b_gap", ev_q[rd_idx+1].c - ev_q[rd_idx].c, FRAME_BITS_NOPAR * OS);
    check_ev("b2b_first",  st1 + FRAME_BITS_NOPAR * OS + 2, 1'b1, 1'b0, 1'b0, 8'h11);
    check_ev("b2b_second", st2 + FRAME_BITS_NOPAR * OS + 2, 1'b1, 1'b0, 1'b0, 8'hEE);
    last_good = 8'hEE;

    // Reset in the middle of a 0xFF frame.
    bus.PAR_EN = 1'b0;
    bus.RX_IN  = 1'b0;
    tick(OS);
    bus.RX_IN  = 1'b1;
    tick(3 * OS + OS / 2);
    RST = 1'b0;
    #2;
    chk("midrst_idle",  (dut.state_r == ST_IDLE), 1'b1);
    chk("midrst_pdata", bus.P_DATA, 8'h00);
    chk("midrst_sync",  dut.rx_s, 1'b1);
    tick(3);
    RST = 1'b1;
    last_good = 8'h00;
    tick(FRAME_BITS_NOPAR * OS);
    check_count("midrst_nopulse", 0);
    run_frame("42_after_rst", 8'h42, 1'b0, PAR_TYP_EVEN, 1'b0, 1'b1);

    // Random frames with occasional parity or stop corruption.
    for (int k = 0; k < 12; k++) begin
      d    = 8'($urandom);
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      pbit = model_parity(d, ptyp) ^ ($urandom_range(0, 3) == 0);
      sbit = !($urandom_range(0, 3) == 0);
      run_frame($sformatf("rand%0d", k), d, pen, ptyp, pbit, sbit);
      tick($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

UART receive path: an oversampled, start-bit-qualified deserializer that recovers 8-bit frames from the serial line. Frames are LSB-first, with an optional parity bit and one stop bit. It is the receive-side counterpart of the TX serializer/FSM chain and sits between the pad-level `RX_IN` and the system register/FIFO interface. It reports a one-cycle `data_valid` pulse per good frame and one-cycle error pulses per bad frame.

## Interface
- `OVERSAMPLE`, 8 — clock cycles per bit; legal values 8, 16, 32.
- `DATA_WIDTH`, 8 — payload bits per frame.
- `CLK` input 1 — single clock, all logic on rising edge.
- `RST` input 1 — reset, asynchronous, active-low.
- `RX_IN` input 1 — asynchronous serial line, idle high.
- `PAR_EN` input 1 — 1: frame carries a parity bit.
- `PAR_TYP` input 1 — 0: even parity, 1: odd parity.
- `P_DATA` output `DATA_WIDTH` — last good payload; reset 0.
- `data_valid` output 1 — one-cycle pulse, `P_DATA` updated this cycle; reset 0.
- `par_err` output 1 — one-cycle pulse, parity mismatch; reset 0.
- `stop_err` output 1 — one-cycle pulse, stop bit sampled 0; reset 0.

## Operation
- `RX_IN` passes through a 2-flop synchronizer; `rx_s` denotes its output. All behaviour below refers to `rx_s`.
- Counters:
  - `edge_cnt` counts 0..`OVERSAMPLE`-1 within a bit.
  - `bit_cnt` indexes the bit within the frame: start = 0, data = 1..8, parity = 9 if enabled, stop = last.
- Sampling: `rx_s` is captured at `edge_cnt` = OS/2-1, OS/2 and OS/2+1. The bit value is the 2-of-3 majority, valid from `edge_cnt` = OS/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - **IDLE**: when `rx_s`=0, go to START, clear counters and latch `PAR_EN`/`PAR_TYP` for the whole frame.
  - **START**:
    - If the majority value is 1, it is a glitch: return to IDLE at OS/2+2 with no output.
    - Otherwise go to DATA at `edge_cnt`=OS-1.
  - **DATA**: shift the majority value into the shift register, LSB first. After bit 8 ends, go to PARITY if `PAR_EN` is latched, else STOP.
  - **PARITY**: compute expected parity as XOR of the payload XOR `PAR_TYP` and compare it with the majority value. Hold the mismatch flag; go to STOP at the end of the bit.
  - **STOP**: at the last cycle of the stop bit, return to IDLE and register the outputs:
    - stop sample 0 → `stop_err`=1.
    - parity mismatch → `par_err`=1.
    - both errors are reported together if both occur.
    - no error → `data_valid`=1 and `P_DATA` loaded.
- `P_DATA` changes only with `data_valid`; it holds its value across bad frames.
- Line held low after a stop error: the FSM sees `rx_s`=0 in IDLE and treats it as a new start. A break will fail the start check only if the line rises; otherwise it produces repeated `stop_err`. This is accepted.
- `PAR_EN`/`PAR_TYP` changes mid-frame are ignored until the next start.

## Timing
- t0 = first cycle `rx_s`=0 in IDLE, which is 2 cycles after the `RX_IN` falling edge.
- Bit k spans cycles t0+k·OS .. t0+(k+1)·OS-1. Frame length N = 10, or 11 with parity.
- Outputs pulse in cycle t0+N·OS; the FSM is in IDLE that same cycle.
  - A start edge arriving at t0+N·OS is detected, so back-to-back frames need no idle gap.
- Glitch rejection: for a low pulse shorter than OS/2-1 cycles, the FSM is back in IDLE at t0+OS/2+3.
- Reset asserted mid-frame:
  - all state, counters, synchronizer (to 1) and outputs clear immediately;
  - no pulse is emitted;
  - after deassertion the block waits for a fresh falling edge.
- Latency, `RX_IN` falling edge → `data_valid`: N·OS+2 cycles.

## Structure
- Package `uart_rx_pkg`:
  - FSM state enum;
  - localparams `SAMPLE_MID` = OS/2, `FRAME_BITS_NOPAR` = 10, `FRAME_BITS_PAR` = 11;
  - parity-type encoding constants.
- Sub-module `uart_rx_data_sampler`: takes `rx_s`, `edge_cnt` and `OVERSAMPLE`; produces the 3-point capture, the majority bit and a `sample_ready` strobe.
- The top level holds the synchronizer, counters, FSM, shift register and output registers.

## Test plan
- OS=8, `PAR_EN`=0, send 0xA5 with stop=1 → `P_DATA`=0xA5, `data_valid` high exactly 1 cycle at edge+82, no errors.
- `PAR_EN`=1, `PAR_TYP`=0, send 0x3C with parity 0 → `data_valid`, `P_DATA`=0x3C. Same frame with parity 1 → `par_err` pulse, no `data_valid`, `P_DATA` stays 0x3C.
- `PAR_TYP`=1, send 0x3C with parity 1 → valid. Then 0x01 with stop=0 → `stop_err` only, `P_DATA` unchanged.
- `RX_IN` low for 2 cycles, then high → no output pulses, FSM back in IDLE, a following frame 0x5A is received correctly.
- Two frames 0x11, 0xEE with zero idle gap → two `data_valid` pulses exactly N·OS cycles apart, with the correct data each.
- Reset asserted at bit 4 of 0xFF, then released, then 0x42 sent → no pulse for the aborted frame, `P_DATA`=0x42 with a single `data_valid`.
